// File: rtl/exe_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit; define EXE_MDU_EARLY_OUT_EN for 1-cycle special-case results.
// Latency N+1 (N = XLEN/MUL_STEP for MUL*, XLEN for DIV/REM); result holds in DONE until res_rdy_i, no issue while busy.
module exe_mdu #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_v_i,
  output logic            req_rdy_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_adr_i,
  input  logic            kill_i,
  output logic            res_v_o,
  input  logic            res_rdy_i,
  output logic [XLEN-1:0] res_data_o,
  output logic [4:0]      res_rd_adr_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] MUL_CNT = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(XLEN - 1);

`ifdef EXE_MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic              accept, done_ld;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] mcand_q, acc_q;
  logic [XLEN-1:0]   mplier_q;
  logic              neg_q, rneg_q, spec_q;
  logic [XLEN-1:0]   spec_res_q, res_data_q;
  logic [4:0]        res_rd_q;

  // request decode: operand magnitudes, signs and the special cases
  logic            is_div_in, s1_sgn, s2_sgn, a_neg, b_neg;
  logic            div0_in, ovf_in, mul0_in, spec_in;
  logic [XLEN-1:0] a_mag, b_mag, spec_res_in;

  always_comb begin
    is_div_in   = op_i[2];
    s1_sgn      = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
    s2_sgn      = s1_sgn && (op_i != OP_MULHSU);
    a_neg       = s1_sgn & rs1_data_i[XLEN-1];
    b_neg       = s2_sgn & rs2_data_i[XLEN-1];
    a_mag       = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag       = b_neg ? -rs2_data_i : rs2_data_i;
    div0_in     = is_div_in && (rs2_data_i == '0);
    ovf_in      = is_div_in && !op_i[0] && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_data_i);
    mul0_in     = !is_div_in && ((rs1_data_i == '0) || (rs2_data_i == '0));
    spec_in     = div0_in | ovf_in | mul0_in;
    spec_res_in = '0;
    if (div0_in)     spec_res_in = op_i[1] ? rs1_data_i : '1;
    else if (ovf_in) spec_res_in = op_i[1] ? '0 : rs1_data_i;
  end

  // one iteration step; divide reuses mplier_q as dividend/quotient and acc_q as remainder
  logic [2*XLEN-1:0] pp, mul_acc_nxt, prod;
  logic [XLEN:0]     rem_sh, diff;
  logic              quo_bit;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_fin, rem_fin, fin_res;

  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
    mul_acc_nxt = acc_q + pp;
    rem_sh      = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
    diff        = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
    quo_bit     = ~diff[XLEN];
    rem_nxt     = quo_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt     = {mplier_q[XLEN-2:0], quo_bit};
    prod        = neg_q ? -mul_acc_nxt : mul_acc_nxt;
    quo_fin     = neg_q ? -quo_nxt : quo_nxt;
    rem_fin     = rneg_q ? -rem_nxt : rem_nxt;
    if (spec_q)              fin_res = spec_res_q;
    else if (op_q[2])        fin_res = op_q[1] ? rem_fin : quo_fin;
    else if (op_q == OP_MUL) fin_res = prod[XLEN-1:0];
    else                     fin_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_ld = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_v_i && !kill_i) begin
          accept  = 1'b1;
          state_d = (EARLY_OUT && spec_in) ? DONE : CALC;
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          done_ld = 1'b1;
        end
      end
      DONE: begin
        if (kill_i || res_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
    end else if (accept) begin
      op_q       <= op_i;
      rd_q       <= rd_adr_i;
      cnt_q      <= is_div_in ? DIV_CNT : MUL_CNT;
      mcand_q    <= {{XLEN{1'b0}}, (is_div_in ? b_mag : a_mag)};
      mplier_q   <= is_div_in ? a_mag : b_mag;
      acc_q      <= '0;
      neg_q      <= a_neg ^ b_neg;
      rneg_q     <= a_neg;
      spec_q     <= spec_in;
      spec_res_q <= spec_res_in;
      if (EARLY_OUT && spec_in) begin
        res_data_q <= spec_res_in;
        res_rd_q   <= rd_adr_i;
      end
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q - 1'b1;
      if (op_q[2]) begin
        acc_q    <= {{XLEN{1'b0}}, rem_nxt};
        mplier_q <= quo_nxt;
      end else begin
        acc_q    <= mul_acc_nxt;
        mcand_q  <= mcand_q << MUL_STEP;
        mplier_q <= mplier_q >> MUL_STEP;
      end
      if (done_ld) begin
        res_data_q <= fin_res;
        res_rd_q   <= rd_q;
      end
    end
  end

  assign req_rdy_o    = (state_q == IDLE) & ~reset;
  assign res_v_o      = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign res_data_o   = res_data_q;
  assign res_rd_adr_o = res_rd_q;

endmodule
